mem_arbiter: RTL and testbench

//  Shares the single-port unified word memory between the fetch (IF) port and the data (MEM) port of the pipelined CPU.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arb_priority.sv | 37 +++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and owner codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner select for the arbiter: data port wins unless fetch has been starved
// for STARVE_LIMIT consecutive data grants.
module mem_arb_priority #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant_dm
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve;
  logic          starved;

  assign starved  = (starve == SW'(STARVE_LIMIT));
  assign grant_dm = dm_req & ~(if_req & starved);

  // Only IDLE cycles (arb_en) count; a fetch grant or an idle fetch port resets the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (arb_en) begin
      if (!if_req) begin
        starve <= '0;
      end else if (grant_dm) begin
        if (!starved) starve <= starve + 1'b1;
      end else begin
        starve <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port unified memory arbiter between the fetch (IF) and data (MEM) ports.
// state      | meaning
// ARB_IDLE   | arbitrate, register winner request, load latency timer
// ARB_ACCESS | mem_en held for LATENCY cycles, timer counts down to 0
// ARB_RESP   | one-cycle ready to owner, read data passed through and captured
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  arb_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic              req_we;
  logic [DATA_W-1:0] if_hold;
  logic [DATA_W-1:0] dm_hold;
  logic              grant_dm;
  logic              arb_en;

  assign arb_en = (state == ARB_IDLE);

  mem_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (arb_en),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant_dm(grant_dm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      owner     <= OWN_IF;
      req_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_hold   <= '0;
      dm_hold   <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (if_req || dm_req) begin
            owner  <= grant_dm ? OWN_DM : OWN_IF;
            req_we <= grant_dm & dm_we;
            mem_en <= 1'b1;
            mem_we <= grant_dm & dm_we;
            mem_addr <= grant_dm ? dm_addr : if_addr;
            if (grant_dm) mem_wdata <= dm_wdata;
            cnt    <= CNT_W'(LATENCY - 1);
            state  <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt == '0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner == OWN_DM) dm_ready <= 1'b1;
            else                 if_ready <= 1'b1;
            state  <= ARB_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ARB_RESP: begin
          if (owner == OWN_IF)      if_hold <= mem_rdata;
          else if (!req_we)         dm_hold <= mem_rdata;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Read data is live in RESP (memory output is only valid then) and held afterwards.
  assign if_rdata = (state == ARB_RESP && owner == OWN_IF) ? mem_rdata : if_hold;
  assign dm_rdata = (state == ARB_RESP && owner == OWN_DM && !req_we) ? mem_rdata : dm_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=1 instance for arbitration/starvation,
// LATENCY=3 instance for mid-access reset recovery.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  logic        rst, if_req, if_ready, dm_req, dm_we, dm_ready, mem_en, mem_we;
  logic [9:0]  if_addr, dm_addr, mem_addr;
  logic [31:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;

  logic        rst2, if_req2, if_ready2, dm_req2, dm_we2, dm_ready2, mem_en2, mem_we2;
  logic [9:0]  if_addr2, dm_addr2, mem_addr2;
  logic [31:0] if_rdata2, dm_wdata2, dm_rdata2, mem_wdata2, mem_rdata2;

  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];

  typedef struct {
    logic        dm;
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] last_dm;

  mem_arbiter #(.DATA_W(32), .ADDR_W(10), .LATENCY(1), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.DATA_W(32), .ADDR_W(10), .LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk(clk), .rst(rst2),
    .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_ready(if_ready2),
    .dm_req(dm_req2), .dm_we(dm_we2), .dm_addr(dm_addr2), .dm_wdata(dm_wdata2),
    .dm_rdata(dm_rdata2), .dm_ready(dm_ready2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2)
  );

  // Synchronous-read memories: data appears the cycle after an enabled edge.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem1[mem_addr];
      if (mem_we) mem1[mem_addr] = mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (mem_en2) begin
      mem_rdata2 <= mem2[mem_addr2];
      if (mem_we2) mem2[mem_addr2] = mem_wdata2;
    end
  end

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 | 32'(a * 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic dm, input logic [31:0] data, input int lat);
    exp_t e;
    e.dm = dm; e.data = data; e.lat = lat;
    sbq.push_back(e);
  endtask

  // Wait (bounded) for a ready on the chosen instance, then check it against the queue head.
  task automatic collect(input string tag, input int start, input bit d2);
    exp_t e;
    int   n;
    bit   got;
    n = start;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = d2 ? (if_ready2 | dm_ready2) : (if_ready | dm_ready);
    end
    chk({tag, "_timeout"}, 32'(got), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sbq.size() > 0), 32'd1);
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_lat"}, 32'(n), 32'(e.lat));
      if (d2) begin
        chk({tag, "_dm_ready"}, 32'(dm_ready2), 32'(e.dm));
        chk({tag, "_if_ready"}, 32'(if_ready2), 32'(!e.dm));
        chk({tag, "_rdata"}, e.dm ? dm_rdata2 : if_rdata2, e.data);
      end else begin
        chk({tag, "_dm_ready"}, 32'(dm_ready), 32'(e.dm));
        chk({tag, "_if_ready"}, 32'(if_ready), 32'(!e.dm));
        chk({tag, "_rdata"}, e.dm ? dm_rdata : if_rdata, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = pat(i);
      mem2[i] = pat(i);
    end
    mem1[4]    = 32'h2008_000A;
    mem1[8]    = 32'h1111_2222;
    mem1[16]   = 32'h0000_BEEF;
    mem2[4]    = 32'h0BAD_F00D;

    rst = 1'b1; if_req = 1'b1; if_addr = 10'h008;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010; dm_wdata = '0;
    rst2 = 1'b1; if_req2 = 1'b0; if_addr2 = '0;
    dm_req2 = 1'b0; dm_we2 = 1'b0; dm_addr2 = '0; dm_wdata2 = '0;

    // Reset with both requests high
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      chk("rst_dm_ready", 32'(dm_ready), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Both request: data first, fetch three cycles later
    push(1'b1, 32'h0000_BEEF, 3);
    push(1'b0, 32'h1111_2222, 3);
    collect("both_dm_first", 0, 1'b0);
    dm_req = 1'b0;
    chk("both_if_rdata_untouched", if_rdata, 32'd0);
    collect("both_if_second", 0, 1'b0);
    if_req = 1'b0;
    chk("both_dm_rdata_held", dm_rdata, 32'h0000_BEEF);
    last_dm = 32'h0000_BEEF;

    // Fetch only
    @(posedge clk); #1;
    if_addr = 10'h004; if_req = 1'b1;
    push(1'b0, 32'h2008_000A, 3);
    @(negedge clk);
    chk("fetch_idle_no_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("fetch_mem_en", 32'(mem_en), 32'd1);
    chk("fetch_mem_addr", 32'(mem_addr), 32'h004);
    chk("fetch_mem_we", 32'(mem_we), 32'd0);
    collect("fetch_only", 2, 1'b0);
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_ready_pulse_end", 32'(if_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("fetch_rdata_hold", if_rdata, 32'h2008_000A);
    @(posedge clk); #1;

    // Data write then read-back
    dm_we = 1'b1; dm_addr = 10'h020; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
    push(1'b1, last_dm, 3);
    @(negedge clk);
    @(negedge clk);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h020);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    collect("write", 2, 1'b0);
    dm_we = 1'b0;
    push(1'b1, 32'hDEAD_BEEF, 3);
    collect("readback", 0, 1'b0);
    dm_req = 1'b0;
    last_dm = 32'hDEAD_BEEF;
    chk("wr_if_rdata_untouched", if_rdata, 32'h2008_000A);
    @(posedge clk); #1;

    // Starvation: four data grants, forced fetch, counter cleared
    if_addr = 10'h008; if_req = 1'b1;
    dm_addr = 10'h040; dm_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(1'b1, pat(16'h40 + i), 3);
      collect("starve_dm", 0, 1'b0);
      dm_addr = 10'(16'h41 + i);
    end
    push(1'b0, 32'h1111_2222, 3);
    collect("starve_fetch_forced", 0, 1'b0);
    if_addr = 10'h009;
    push(1'b1, pat(16'h44), 3);
    collect("starve_cleared_dm", 0, 1'b0);
    dm_req = 1'b0;
    push(1'b0, pat(9), 3);
    collect("starve_fetch_tail", 0, 1'b0);
    if_req = 1'b0;

    // LATENCY=3 instance: reset in second ACCESS cycle, then recovery
    @(posedge clk); #1;
    rst2 = 1'b0; if_addr2 = 10'h004; if_req2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat3_access_en", 32'(mem_en2), 32'd1);
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat3_rst_mem_en", 32'(mem_en2), 32'd0);
    chk("lat3_rst_if_ready", 32'(if_ready2), 32'd0);
    chk("lat3_rst_dm_ready", 32'(dm_ready2), 32'd0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    push(1'b0, 32'h0BAD_F00D, 5);
    collect("lat3_after_reset", 0, 1'b1);
    if_req2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
